// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: issues ops to an external multiplier and divider and
// writes HI/LO back. Define MULDIV_DIVZERO_FAST_EN to resolve divide-by-zero without the divider.
module muldiv_ctrl #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mul_start_o,
    output logic        mul_signed_o,
    input  logic [63:0] mul_prod_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic        div_cancel_o,
    input  logic        div_done_i,
    input  logic [31:0] div_quot_i,
    input  logic [31:0] div_rem_i,
    output logic        whilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMadd  = 4'd5;
    localparam logic [3:0] OpMaddu = 4'd6;
    localparam logic [3:0] OpMsub  = 4'd7;
    localparam logic [3:0] OpMsubu = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StMulWait,
        StDivWait,
        StDone
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  op_q;
    logic [63:0] acc_q;
    logic [63:0] res_q;

    logic op_legal;
    logic op_is_div;
    logic op_signed;
    logic div_fast;
    logic accept;
    logic [63:0] mul_result;

    assign op_legal  = (op_i >= OpMult) && (op_i <= OpMsubu);
    assign op_is_div = (op_i == OpDiv) || (op_i == OpDivu);
    assign op_signed = (op_i == OpMult) || (op_i == OpDiv) ||
                       (op_i == OpMadd) || (op_i == OpMsub);

`ifdef MULDIV_DIVZERO_FAST_EN
    assign div_fast = op_is_div && (rt_i == 32'd0);
`else
    assign div_fast = 1'b0;
`endif

    // Operands go straight to the multiplier/divider; only the divide-by-zero path reads them.
    logic unused_operands;
    assign unused_operands = ^{rs_i, rt_i};

    // Gated by rst so no issue pulse can escape while reset is held.
    assign accept = !rst && valid_i && op_legal && !flush_i && (state_q == StIdle);

    assign mul_start_o  = accept && !op_is_div;
    assign mul_signed_o = mul_start_o && op_signed;
    assign div_start_o  = accept && op_is_div && !div_fast;
    assign div_signed_o = div_start_o && op_signed;
    assign div_cancel_o = (state_q == StDivWait) && flush_i;

    assign stall_o    = accept || (state_q == StMulWait) || (state_q == StDivWait);
    assign whilo_we_o = (state_q == StDone) && !flush_i;
    assign hi_o       = res_q[63:32];
    assign lo_o       = res_q[31:0];

    always_comb begin
        mul_result = mul_prod_i;
        unique case (op_q)
            OpMadd, OpMaddu: mul_result = acc_q + mul_prod_i;
            OpMsub, OpMsubu: mul_result = acc_q - mul_prod_i;
            default:         mul_result = mul_prod_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            acc_q   <= 64'd0;
            res_q   <= 64'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q  <= op_i;
                        acc_q <= {hi_i, lo_i};
                        if (div_fast) begin
                            res_q   <= {rs_i, 32'hFFFF_FFFF};
                            state_q <= StDone;
                        end else if (op_is_div) begin
                            state_q <= StDivWait;
                        end else begin
                            cnt_q   <= 4'(MUL_LATENCY);
                            state_q <= StMulWait;
                        end
                    end
                end
                StMulWait: begin
                    if (flush_i) begin
                        cnt_q   <= 4'd0;
                        state_q <= StIdle;
                    end else if (cnt_q == 4'd1) begin
                        res_q   <= mul_result;
                        cnt_q   <= 4'd0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDivWait: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (div_done_i) begin
                        res_q   <= {div_rem_i, div_quot_i};
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier and divider models.
// Build with MULDIV_DIVZERO_FAST_EN to exercise the fast divide-by-zero path.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [3:0]  op_i = 4'd0;
    logic [31:0] rs_i = 32'd0, rt_i = 32'd0, hi_i = 32'd0, lo_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        stall_o, mul_start_o, mul_signed_o;
    logic [63:0] mul_prod_i;
    logic        div_start_o, div_signed_o, div_cancel_o, div_done_i;
    logic [31:0] div_quot_i, div_rem_i;
    logic        whilo_we_o;
    logic [31:0] hi_o, lo_o;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .op_i        (op_i),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .mul_start_o (mul_start_o),
        .mul_signed_o(mul_signed_o),
        .mul_prod_i  (mul_prod_i),
        .div_start_o (div_start_o),
        .div_signed_o(div_signed_o),
        .div_cancel_o(div_cancel_o),
        .div_done_i  (div_done_i),
        .div_quot_i  (div_quot_i),
        .div_rem_i   (div_rem_i),
        .whilo_we_o  (whilo_we_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_push = 0;
    int writes = 0;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: product valid only in cycle MUL_LAT after the start pulse.
    int          mcnt = 0;
    logic [63:0] mprod = 64'd0;
    always @(posedge clk) begin
        if (mul_start_o) begin
            mcnt  <= 1;
            mprod <= mul_signed_o ? ({{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i})
                                  : ({32'd0, rs_i} * {32'd0, rt_i});
        end else if (mcnt != 0 && mcnt < 64) begin
            mcnt <= mcnt + 1;
        end
    end
    assign mul_prod_i = (mcnt == MUL_LAT) ? mprod : 64'hBAD0_BAD0_BAD0_BAD0;

    // Divider model: done pulses div_lat cycles after start, with bench-chosen results.
    int          dcnt = 0;
    int          div_lat = 33;
    int          n_cancel = 0;
    int          n_dstart = 0;
    logic [31:0] dquot = 32'd0, drem = 32'd0;
    always @(posedge clk) begin
        if (div_start_o) begin
            dcnt     <= 1;
            n_dstart <= n_dstart + 1;
        end else if (div_cancel_o) begin
            dcnt <= 0;
        end else if (dcnt != 0 && dcnt < 200) begin
            dcnt <= dcnt + 1;
        end
        if (div_cancel_o) n_cancel <= n_cancel + 1;
    end
    assign div_done_i = (dcnt == div_lat);
    assign div_quot_i = div_done_i ? dquot : 32'hBAD1_BAD1;
    assign div_rem_i  = div_done_i ? drem  : 32'hBAD2_BAD2;

    int run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (stall_o) begin
            run <= run + 1;
        end else if (run > 0) begin
            last_run <= run;
            run      <= 0;
        end
    end

    // Monitor: every HI/LO write must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        if (whilo_we_o) begin
            exp_t e;
            writes++;
            if (sbq.size() == 0) begin
                chk("unexpected_write", {hi_o, lo_o}, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("write_cycle", 64'(cyc), 64'(e.cyc));
                chk("write_data", {hi_o, lo_o}, e.val);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; drives one op for a single cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] hi, input logic [31:0] lo, input bit exp_mul,
                         input bit exp_div, input bit exp_sgn, input bit push,
                         input logic [63:0] val, input int lat);
        exp_t e;
        valid_i = 1'b1;
        op_i = op;
        rs_i = rs;
        rt_i = rt;
        hi_i = hi;
        lo_i = lo;
        @(negedge clk);
        chk("mul_start", 64'(mul_start_o), 64'(exp_mul));
        chk("div_start", 64'(div_start_o), 64'(exp_div));
        chk("signed", 64'(mul_signed_o | div_signed_o), 64'(exp_sgn));
        chk("accept_stall", 64'(stall_o), 64'd1);
        if (push) begin
            e.cyc = cyc + lat;
            e.val = val;
            sbq.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        op_i = 4'd0;
    endtask

    int dstart_before;

    initial begin
        // Reset with a valid op presented: nothing may leak out.
        valid_i = 1'b1;
        op_i = 4'd1;
        rs_i = 32'd3;
        rt_i = 32'd3;
        repeat (2) @(negedge clk);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_mul_start", 64'(mul_start_o), 64'd0);
        chk("rst_div_start", 64'(div_start_o), 64'd0);
        chk("rst_we", 64'(whilo_we_o), 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Illegal op and flush in IDLE are not accepted.
        op_i = 4'd9;
        @(negedge clk);
        chk("op9_stall", 64'(stall_o), 64'd0);
        chk("op9_start", 64'(mul_start_o | div_start_o), 64'd0);
        @(posedge clk);
        #1;
        op_i = 4'd1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("idle_flush_start", 64'(mul_start_o), 64'd0);
        chk("idle_flush_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        op_i = 4'd0;

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 1, 0, 1, 1,
              64'hFFFF_FFFF_FFFF_FFFA, MUL_LAT + 1);
        idle(6);
        chk("mult_stall_len", 64'(last_run), 64'd3);
        issue(4'd6, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1, 0, 0, 1,
              64'h0000_0001_0000_0000, MUL_LAT + 1);
        idle(5);
        issue(4'd7, 32'd2, 32'd3, 32'd0, 32'd0, 1, 0, 1, 1,
              64'hFFFF_FFFF_FFFF_FFFA, MUL_LAT + 1);
        idle(5);
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 0, 0, 1,
              64'hFFFF_FFFE_0000_0001, MUL_LAT + 1);
        idle(5);
        issue(4'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 1,
              64'hFFFF_FFFF_FFFF_FFFD, MUL_LAT + 1);
        idle(5);

        // DIV -7 / 2 with a 33-cycle divider.
        div_lat = 33;
        dquot = 32'hFFFF_FFFD;
        drem = 32'hFFFF_FFFF;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0, 1, 1, 1,
              64'hFFFF_FFFF_FFFF_FFFD, 34);
        idle(40);
        chk("div_stall_len", 64'(last_run), 64'd34);

        // Flush on the 10th DIV_WAIT cycle, then a MULTU right away.
        issue(4'd4, 32'd100, 32'd7, 32'd0, 32'd0, 0, 1, 0, 0, 64'd0, 0);
        idle(9);
        flush_i = 1'b1;
        @(negedge clk);
        chk("cancel_pulse", 64'(div_cancel_o), 64'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        issue(4'd2, 32'd3, 32'd5, 32'd0, 32'd0, 1, 0, 0, 1, 64'd15, MUL_LAT + 1);
        idle(6);
        chk("cancel_count_1", 64'(n_cancel), 64'd1);

        // div_done_i coincident with flush: no write.
        div_lat = 5;
        issue(4'd3, 32'd9, 32'd3, 32'd0, 32'd0, 0, 1, 1, 0, 64'd0, 0);
        idle(4);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("done_flush_we", 64'(whilo_we_o), 64'd0);
        chk("done_flush_idle", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        idle(3);

        // Reset pulse mid MUL_WAIT, then immediate accept.
        issue(4'd1, 32'd5, 32'd5, 32'd0, 32'd0, 1, 0, 1, 0, 64'd0, 0);
        rst = 1'b1;
        valid_i = 1'b1;
        op_i = 4'd2;
        @(negedge clk);
        chk("midrst_stall", 64'(stall_o), 64'd0);
        chk("midrst_start", 64'(mul_start_o | div_start_o), 64'd0);
        chk("midrst_we", 64'(whilo_we_o | div_cancel_o), 64'd0);
        chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(4'd2, 32'd7, 32'd6, 32'd0, 32'd0, 1, 0, 0, 1, 64'd42, MUL_LAT + 1);
        idle(5);

        // Flush in MUL_WAIT drops the op; flush in DONE suppresses the write.
        issue(4'd2, 32'd2, 32'd2, 32'd0, 32'd0, 1, 0, 0, 0, 64'd0, 0);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("mulwait_flush_idle", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        issue(4'd2, 32'd3, 32'd3, 32'd0, 32'd0, 1, 0, 0, 0, 64'd0, 0);
        idle(2);
        flush_i = 1'b1;
        @(negedge clk);
        chk("done_flush_we2", 64'(whilo_we_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        idle(3);

        // An op presented in DONE waits for the following IDLE cycle.
        issue(4'd2, 32'd4, 32'd4, 32'd0, 32'd0, 1, 0, 0, 1, 64'd16, MUL_LAT + 1);
        idle(2);
        valid_i = 1'b1;
        op_i = 4'd1;
        rs_i = 32'd3;
        rt_i = 32'd3;
        @(negedge clk);
        chk("done_no_accept", 64'(mul_start_o), 64'd0);
        chk("done_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        issue(4'd1, 32'd3, 32'd3, 32'd0, 32'd0, 1, 0, 1, 1, 64'd9, MUL_LAT + 1);
        idle(5);

        // DIVU 5 / 0.
        dstart_before = n_dstart;
`ifdef MULDIV_DIVZERO_FAST_EN
        issue(4'd4, 32'd5, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1,
              64'h0000_0005_FFFF_FFFF, 1);
        idle(4);
        chk("divzero_stall_len", 64'(last_run), 64'd1);
        chk("divzero_no_start", 64'(n_dstart), 64'(dstart_before));
`else
        div_lat = 4;
        dquot = 32'hFFFF_FFFF;
        drem = 32'd5;
        issue(4'd4, 32'd5, 32'd0, 32'd0, 32'd0, 0, 1, 0, 1,
              64'h0000_0005_FFFF_FFFF, 5);
        idle(8);
        chk("divzero_stall_len", 64'(last_run), 64'd5);
        chk("divzero_started", 64'(n_dstart), 64'(dstart_before + 1));
`endif

        idle(5);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        chk("write_count", 64'(writes), 64'(n_push));
        chk("cancel_count", 64'(n_cancel), 64'd2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MUL_LATENCY, default 2: fixed cycle count from mul_start_o to a valid mul_prod_i; legal range 1-15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 valid_i  in  1  EX-stage instruction presents a mul/div op this cycle.
REQ-005 op_i  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU; 9-15 treated as none.
REQ-006 rs_i, rt_i  in  32 each  source operands.
REQ-007 hi_i, lo_i  in  32 each  current forwarded HI/LO values.
REQ-008 flush_i  in  1  exception/branch-likely flush; kills the in-flight op.
REQ-009 stall_o  out  1  pipeline hold request.
REQ-010 mul_start_o, mul_signed_o  out  1 each  multiplier issue pulse and signedness.
REQ-011 mul_prod_i  in  64  multiplier product.
REQ-012 div_start_o, div_signed_o, div_cancel_o  out  1 each  divider issue pulse, signedness and abort pulse.
REQ-013 div_done_i  in  1  divider result valid, one-cycle pulse.
REQ-014 div_quot_i, div_rem_i  in  32 each  divider quotient and remainder.
REQ-015 whilo_we_o  out  1  HI/LO write strobe.
REQ-016 hi_o, lo_o  out  32 each  HI/LO write data.

Function
REQ-017 States: IDLE, MUL_WAIT, DIV_WAIT, DONE; encoded state register.
REQ-018 Accept: valid_i & op legal & !flush_i while in IDLE -> latch rs_i, rt_i, hi_i, lo_i and op, then go to MUL_WAIT for ops 1,2,5-8 or DIV_WAIT for ops 3,4.
REQ-019 mul_start_o / div_start_o pulse combinationally in the accept cycle only.
REQ-020 Signedness: signed for MULT, DIV, MADD, MSUB; unsigned otherwise.
REQ-021 MUL_WAIT: a down-counter loaded with MUL_LATENCY; mul_prod_i is captured when the counter reaches 1; the state then goes to DONE.
REQ-022 DIV_WAIT: hold until div_done_i; capture hi=div_rem_i, lo=div_quot_i; go to DONE.
REQ-023 Result: MULT/MULTU {hi,lo}=prod; MADD/MADDU {hi,lo}=latched {hi,lo}+prod; MSUB/MSUBU {hi,lo}=latched {hi,lo}-prod; 64-bit modulo arithmetic, no overflow trap.
REQ-024 DONE: whilo_we_o=1 for exactly one cycle with hi_o/lo_o valid; stall_o=0; next state IDLE.
REQ-025 stall_o=1 in the accept cycle and in every MUL_WAIT/DIV_WAIT cycle; 0 in IDLE without accept and in DONE.
REQ-026 An op arriving in the DONE cycle is not accepted; it is accepted in the following IDLE cycle, so there is no back-to-back issue.
REQ-027 Total latency, accept to whilo_we_o: MUL_LATENCY+1 cycles for mul ops; divider latency+1 cycles for div ops.
REQ-028 flush_i in MUL_WAIT or DIV_WAIT -> next state IDLE, no write; in DIV_WAIT, div_cancel_o pulses in the same cycle.
REQ-029 flush_i in DONE suppresses whilo_we_o.
REQ-030 flush_i in IDLE blocks acceptance.
REQ-031 div_done_i and flush_i in the same cycle: flush wins, no write.
REQ-032 div_done_i or mul results arriving outside their wait state are ignored.

Reset
REQ-033 rst asserted -> state IDLE, counter 0, latched operands/results 0.
REQ-034 All outputs are 0 during reset, including when reset is asserted mid-operation; no divider cancel is issued, because the divider is reset by the same rst.

Configuration
REQ-035 Macro MULDIV_DIVZERO_FAST_EN defined: a DIV/DIVU with rt_i==0 does not start the divider; it goes directly to DONE with hi_o=rs_i and lo_o=32'hFFFF_FFFF (1-cycle stall).
REQ-036 Macro MULDIV_DIVZERO_FAST_EN undefined: divide-by-zero is issued to the divider like any other divide, and its result is forwarded unmodified.

Verification
REQ-037 MULT rs=0xFFFFFFFE, rt=3, MUL_LATENCY=2 -> stall_o high 3 cycles; whilo_we_o with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 MADDU hi=0, lo=0xFFFFFFFF, rs=1, rt=1 -> hi=1, lo=0 (carry into HI).
REQ-039 DIV rs=-7, rt=2, divider done after 33 cycles -> quot 0xFFFFFFFD, rem 0xFFFFFFFF written; stall_o high 34 cycles.
REQ-040 Flush on 10th DIV_WAIT cycle -> div_cancel_o single pulse; no whilo_we_o; IDLE next cycle; new MULTU accepted next.
REQ-041 div_done_i coincident with flush_i -> no write.
REQ-042 rst pulse during MUL_WAIT -> all outputs 0; a new op is accepted in the first cycle after rst deasserts.
REQ-043 With MULDIV_DIVZERO_FAST_EN: DIVU rs=5, rt=0 -> div_start_o never asserted; hi=5, lo=0xFFFFFFFF one cycle after accept.
